// File: rtl/free_list_multi_if.sv
// free_list_multi_if: rename/commit-side bundle of the multi-port free list
//   master: drives alloc request, frees and checkpoint controls; slave: the free list
interface free_list_multi_if #(
  parameter int NUM_PHYS_REGS = 64,
  parameter int ALLOC_WIDTH = 2,
  parameter int FREE_WIDTH = 2
);
  localparam int LP = $clog2(NUM_PHYS_REGS);
  localparam int CW = $clog2(NUM_PHYS_REGS + 1);
  localparam int AW = $clog2(ALLOC_WIDTH + 1);
  logic [AW-1:0] Alloc_Count_IN;
  logic Alloc_Grant_OUT;
  logic [ALLOC_WIDTH*LP-1:0] Alloc_Data_OUT;
  logic [FREE_WIDTH-1:0] Free_Valid_IN;
  logic [FREE_WIDTH*LP-1:0] Free_Data_IN;
  logic Ckpt_Save_IN;
  logic Ckpt_Release_IN;
  logic Ckpt_Restore_IN;
  logic [CW-1:0] Count_OUT;
  logic Overflow_OUT;
  modport master (
    output Alloc_Count_IN, Free_Valid_IN, Free_Data_IN, Ckpt_Save_IN, Ckpt_Release_IN, Ckpt_Restore_IN,
    input Alloc_Grant_OUT, Alloc_Data_OUT, Count_OUT, Overflow_OUT
  );
  modport slave (
    input Alloc_Count_IN, Free_Valid_IN, Free_Data_IN, Ckpt_Save_IN, Ckpt_Release_IN, Ckpt_Restore_IN,
    output Alloc_Grant_OUT, Alloc_Data_OUT, Count_OUT, Overflow_OUT
  );
endinterface

// File: rtl/free_list_multi.sv
// free_list_multi: multi-port physical register free list with a one-level branch checkpoint
//   CLK/RESET (async, active-low); fl.slave: alloc count/grant/data (combinational),
//   per-slot frees, checkpoint save/release/restore, registered Count_OUT, sticky Overflow_OUT
module free_list_multi #(
  parameter int NUM_PHYS_REGS = 64,
  parameter int NUM_ARCH_REGS = 32,
  parameter int ALLOC_WIDTH = 2,
  parameter int FREE_WIDTH = 2
) (
  input logic CLK,
  input logic RESET,
  free_list_multi_if.slave fl
);
  localparam int LP = $clog2(NUM_PHYS_REGS);
  localparam int CW = $clog2(NUM_PHYS_REGS + 1);
  localparam int INIT = NUM_PHYS_REGS - NUM_ARCH_REGS;
  logic [LP-1:0] r_queue [NUM_PHYS_REGS];
  logic [LP-1:0] r_head, r_tail, r_ckpt_head;
  logic [CW-1:0] r_count, r_alloc_since;
  logic r_ckpt_valid, r_overflow;
  logic w_grant, w_drop;
  logic [CW-1:0] w_alloc_n, w_cap, w_nwr;
  logic [LP-1:0] w_head_nx;
  logic [FREE_WIDTH-1:0] w_wr_en;
  logic [LP-1:0] w_wr_idx [FREE_WIDTH];
  // Capacity excludes entries allocated since the checkpoint, so a rollback finds them intact.
  always_comb begin
    w_grant = RESET && !fl.Ckpt_Restore_IN && (CW'(fl.Alloc_Count_IN) <= r_count);
    w_alloc_n = w_grant ? CW'(fl.Alloc_Count_IN) : '0;
    w_head_nx = r_head + LP'(w_alloc_n);
    w_cap = CW'(NUM_PHYS_REGS) - r_count - (r_ckpt_valid ? r_alloc_since : '0);
    w_nwr = '0;
    w_drop = 1'b0;
    w_wr_en = '0;
    for (int j = 0; j < FREE_WIDTH; j++) begin
      w_wr_idx[j] = r_tail + LP'(w_nwr);
      w_wr_en[j] = fl.Free_Valid_IN[j] && (w_nwr < w_cap);
      w_drop = w_drop | (fl.Free_Valid_IN[j] && !(w_nwr < w_cap));
      w_nwr = w_nwr + CW'(w_wr_en[j]);
    end
  end
  for (genvar i = 0; i < ALLOC_WIDTH; i++) begin : g_out
    assign fl.Alloc_Data_OUT[i*LP +: LP] = r_queue[r_head + LP'(i)];
  end
  assign fl.Alloc_Grant_OUT = w_grant;
  assign fl.Count_OUT = r_count;
  assign fl.Overflow_OUT = r_overflow;
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int k = 0; k < NUM_PHYS_REGS; k++)
        r_queue[k] <= (k < INIT) ? LP'(NUM_ARCH_REGS + k) : '0;
      r_head <= '0;
      r_tail <= LP'(INIT);
      r_count <= CW'(INIT);
      r_ckpt_head <= '0;
      r_ckpt_valid <= 1'b0;
      r_alloc_since <= '0;
      r_overflow <= 1'b0;
    end else begin
      for (int j = 0; j < FREE_WIDTH; j++)
        if (w_wr_en[j]) r_queue[w_wr_idx[j]] <= fl.Free_Data_IN[j*LP +: LP];
      r_tail <= r_tail + LP'(w_nwr);
      r_overflow <= r_overflow | w_drop;
      r_head <= (fl.Ckpt_Restore_IN && r_ckpt_valid) ? r_ckpt_head : w_head_nx;
      r_count <= (fl.Ckpt_Restore_IN && r_ckpt_valid) ? r_count + r_alloc_since + w_nwr
                                                      : r_count - w_alloc_n + w_nwr;
      if (fl.Ckpt_Restore_IN) begin
        r_ckpt_valid <= 1'b0;
        r_alloc_since <= '0;
      end else if (fl.Ckpt_Save_IN) begin
        r_ckpt_head <= w_head_nx;
        r_ckpt_valid <= 1'b1;
        r_alloc_since <= '0;
      end else if (fl.Ckpt_Release_IN) begin
        r_ckpt_valid <= 1'b0;
        r_alloc_since <= '0;
      end else if (r_ckpt_valid) begin
        r_alloc_since <= r_alloc_since + w_alloc_n;
      end
    end
  end
endmodule

// File: doc/free_list_multi.md
Name: free_list_multi

Overview:
- Multi-port physical-register free list for the rename stage; the next generation of the single-port free list.
- Allocates up to ALLOC_WIDTH and reclaims up to FREE_WIDTH physical registers per cycle.
- Holds one branch checkpoint, so speculative allocations can be rolled back in one cycle on mispredict.
- Sits between rename (allocation) and commit (free).

Parameters:
- NUM_PHYS_REGS, 64: physical registers and queue depth DEPTH; power of two, at least 4.
- NUM_ARCH_REGS, 32: physical regs 0..NUM_ARCH_REGS-1 are architecturally mapped at reset and start not-free.
- ALLOC_WIDTH, 2: allocation slots per cycle.
- FREE_WIDTH, 2: free slots per cycle.
- LP = clog2(NUM_PHYS_REGS) and CW = clog2(NUM_PHYS_REGS+1) are derived widths.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  reset, asynchronous, active-low.
- Alloc_Count_IN  in  clog2(ALLOC_WIDTH+1)  number of registers requested this cycle (0..ALLOC_WIDTH).
- Alloc_Grant_OUT  out  1  combinational; 1 when the whole request is granted.
- Alloc_Data_OUT  out  ALLOC_WIDTH*LP  combinational; slot i = queue[(head+i) mod DEPTH], valid for slots i < Alloc_Count_IN when granted.
- Free_Valid_IN  in  FREE_WIDTH  per-slot free strobe; any bit pattern is legal.
- Free_Data_IN  in  FREE_WIDTH*LP  register numbers to return.
- Ckpt_Save_IN  in  1  take checkpoint this cycle.
- Ckpt_Release_IN  in  1  discard checkpoint (branch resolved correct).
- Ckpt_Restore_IN  in  1  roll back to checkpoint (mispredict).
- Count_OUT  out  CW  registered number of free entries.
- Overflow_OUT  out  1  sticky error, set when a free is dropped.

Behaviour:
- Reset (async, RESET=0):
  - queue[k] = NUM_ARCH_REGS+k for k < NUM_PHYS_REGS-NUM_ARCH_REGS.
  - head=0; tail=count=NUM_PHYS_REGS-NUM_ARCH_REGS, wrapping tail to 0 when it equals DEPTH.
  - ckpt_valid=0, alloc_since=0, Overflow_OUT=0.
  - Outputs while in reset: Alloc_Grant_OUT=0, Count_OUT=initial count.
- Allocation:
  - All-or-nothing: grant = RESET & !Ckpt_Restore_IN & (Alloc_Count_IN <= count).
  - Alloc_Count_IN=0 gives grant=1 with no state change.
  - Zero-cycle latency: data is valid in the request cycle, and head += Alloc_Count_IN mod DEPTH at posedge when granted.
  - Frees in the same cycle never satisfy that cycle's allocation (no bypass).
- Free:
  - Valid slots are compacted in ascending slot order and written at tail, tail+1, ... (mod DEPTH).
  - Capacity = DEPTH - count - (ckpt_valid ? alloc_since : 0), evaluated before this cycle's allocation.
  - Slots beyond capacity are dropped in ascending order and set Overflow_OUT, which clears only on reset.
  - tail advances by the number written.
- Count: count_next = count - granted_alloc + written_frees. Range 0..DEPTH; no wrap ambiguity.
- Checkpoint, one level:
  - Save: ckpt_head = head after this cycle's allocation; alloc_since=0; ckpt_valid=1. A save while valid overwrites the old checkpoint.
  - While valid: alloc_since += granted alloc count each cycle. Entries between ckpt_head and head are protected from overwrite.
  - Release: ckpt_valid=0, alloc_since=0.
  - Restore with ckpt_valid=1:
    - head = ckpt_head; count = count + alloc_since + written_frees; ckpt_valid=0.
    - No allocation that cycle; frees still apply.
  - Restore with ckpt_valid=0: no-op except that allocation is suppressed.
- Same-cycle priority: Restore > Save > Release. Save+Release means save wins. Restore+Save means the save is ignored.
- Reset mid-operation: all state returns to reset values immediately, including the checkpoint.

Test Plan:
- Reset only, defaults -> Count_OUT=32; Alloc_Count_IN=2 gives Alloc_Data_OUT slots {32,33} and grant=1; next cycle Count_OUT=30 and slots {34,35}.
- Drain 32 regs 2 per cycle, then request 1 -> grant=0, head and count unchanged; Free_Valid=2'b11 with data {5,9} in the same cycle -> next cycle count=2, then allocation returns 5,9 in order.
- Free_Valid=2'b10 with data {x,7} -> single entry 7 written at tail; count+1; no gap in the queue.
- Save with count=10 and alloc 2 (alloc_since=0), then alloc 2+2 over two cycles, free 1, then Restore -> count=10-2+1=9 and the next allocation returns the same regs as the first post-save allocation.
- Fill to count=DEPTH-2 with checkpoint alloc_since=0, free 3 over two cycles -> third free dropped, Overflow_OUT=1 and stays 1 until RESET.
- Restore and Save in the same cycle with alloc 2 requested -> grant=0, checkpoint cleared (subsequent Restore is no-op); assert RESET mid-burst -> Count_OUT=32 asynchronously.
